mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-port memory between pipeline fetch (I side) and load/store (D side, driven by DREQ/DRW from decode).
//  Grants one request at a time, holds it until memory acks or times out, and returns data with a one-cycle valid pulse.
//  Drives STALL to freeze the pipeline while any request is outstanding. Sits between pipeline stages and memory.
// PARAMETERS
//  AW       30  word-address width
//  DW       32  data width
//  TIMEOUT  16  max wait-state cycles before abort; counter width $clog2(TIMEOUT+1)
// PORTS
//  CLK     in   1   clock, all state on rising edge
//  RST     in   1   asynchronous, active-high reset
//  IREQ    in   1   fetch request, level, held until IVALID
//  IADDR   in   AW  fetch address, stable while IREQ high
//  IDATA   out  DW  fetched instruction, valid with IVALID
//  IVALID  out  1   one-cycle fetch completion pulse
//  DREQ    in   1   load/store request, level, held until DVALID
//  DRW     in   1   1 = store, 0 = load
//  DADDR   in   AW  data address
//  DWDATA  in   DW  store data
//  DRDATA  out  DW  load data, valid with DVALID
//  DVALID  out  1   one-cycle data completion pulse
//  STALL   out  1   pipeline hold
//  ERR     out  1   sticky timeout flag
//  MREQ    out  1   memory request, held until MACK
//  MRW     out  1   memory write enable
//  MADDR   out  AW  memory address
//  MWDATA  out  DW  memory write data
//  MRDATA  in   DW  memory read data, sampled when MACK=1
//  MACK    in   1   memory completion, one-cycle pulse
// BEHAVIOUR
//  - Reset: state IDLE, wait counter 0, all outputs 0, including IDATA, DRDATA, MADDR, MWDATA and ERR.
//  - FSM: IDLE, IWAIT, DWAIT.
//  - IDLE transitions, priority D over I (D belongs to the older instruction):
//      DREQ & ~DVALID -> DWAIT;  else IREQ & ~IVALID -> IWAIT.
//    The ~xVALID term blocks re-grant of a request in its retire cycle.
//  - On grant edge: MREQ<=1; MADDR, MRW, MWDATA latched from the winner. An I grant forces MRW=0 and MWDATA=0.
//    Latched values stay constant for the whole WAIT state.
//  - xWAIT & MACK edge: MREQ<=0 and state -> IDLE. The cycle after the edge, xVALID=1 for exactly one cycle.
//  - Load/fetch completion: MRDATA captured into IDATA or DRDATA. A store leaves DRDATA unchanged.
//  - IDATA and DRDATA hold their value until the next completion on that side.
//  - Minimum latency: request seen in IDLE at edge t, MREQ at t+1, MACK at t+1, xVALID at t+2.
//    There is always >=1 IDLE cycle between two MREQ pulses.
//  - Timeout: wait counter clears on grant and increments each WAIT cycle without MACK.
//    At count==TIMEOUT, abort: MREQ<=0, go to IDLE, pulse xVALID with data 0, ERR<=1 (sticky until RST).
//  - MACK in IDLE (late or stray) is ignored.
//  - STALL (combinational) = (IREQ & ~IVALID) | (DREQ & ~DVALID).
//    In a cycle where one side retires while the other is pending, STALL stays 1.
//  - RST mid-WAIT: transaction abandoned, MREQ drops immediately, no VALID pulse is produced.
// TESTING
//  1. IREQ=1, IADDR=0x10, MACK 3 cycles after MREQ with MRDATA=0xDEADBEEF
//     -> MREQ=1, MRW=0, MADDR=0x10; IVALID pulse with IDATA=0xDEADBEEF; STALL low in the IVALID cycle.
//  2. IREQ and DREQ (load, DADDR=0x40) rise together
//     -> MADDR=0x40 first, DVALID, >=1 idle cycle, then MADDR=IADDR, IVALID; STALL high throughout.
//  3. Store: DRW=1, DADDR=0x8, DWDATA=0x1234, MACK after 1 cycle
//     -> MRW=1, MWDATA=0x1234; DVALID pulse; DRDATA keeps its old value.
//  4. TIMEOUT=4, DREQ load, MACK never comes
//     -> MREQ drops after 4 wait cycles; DVALID with DRDATA=0; ERR=1 and stays 1 through later transfers.
//  5. RST asserted during DWAIT, MACK pulses one cycle after release
//     -> all outputs 0, state IDLE, no DVALID, stray MACK ignored.
//  6. IREQ held high with IADDR stepping 0x0 -> 0x1 right after each IVALID
//     -> back-to-back fetches, MADDR 0x0 then 0x1, each with exactly one IVALID.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between instruction fetch and load/store.
// One transaction in flight at a time, with wait-state timeout and a registered completion pulse.
module mem_port_arbiter #(
    parameter int AW      = 30,
    parameter int DW      = 32,
    parameter int TIMEOUT = 16
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          IREQ,
    input  logic [AW-1:0] IADDR,
    output logic [DW-1:0] IDATA,
    output logic          IVALID,
    input  logic          DREQ,
    input  logic          DRW,
    input  logic [AW-1:0] DADDR,
    input  logic [DW-1:0] DWDATA,
    output logic [DW-1:0] DRDATA,
    output logic          DVALID,
    output logic          STALL,
    output logic          ERR,
    output logic          MREQ,
    output logic          MRW,
    output logic [AW-1:0] MADDR,
    output logic [DW-1:0] MWDATA,
    input  logic [DW-1:0] MRDATA,
    input  logic          MACK
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE,
        IWAIT,
        DWAIT
    } state_t;

    state_t        state;
    logic [CW-1:0] wait_cnt;

    assign STALL = (IREQ & ~IVALID) | (DREQ & ~DVALID);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= IDLE;
            wait_cnt <= '0;
            IDATA    <= '0;
            IVALID   <= 1'b0;
            DRDATA   <= '0;
            DVALID   <= 1'b0;
            ERR      <= 1'b0;
            MREQ     <= 1'b0;
            MRW      <= 1'b0;
            MADDR    <= '0;
            MWDATA   <= '0;
        end else begin
            IVALID <= 1'b0;
            DVALID <= 1'b0;
            unique case (state)
                IDLE: begin
                    // The ~xVALID terms stop a request from re-winning in its own retire cycle.
                    if (DREQ && !DVALID) begin
                        state    <= DWAIT;
                        wait_cnt <= '0;
                        MREQ     <= 1'b1;
                        MRW      <= DRW;
                        MADDR    <= DADDR;
                        MWDATA   <= DWDATA;
                    end else if (IREQ && !IVALID) begin
                        state    <= IWAIT;
                        wait_cnt <= '0;
                        MREQ     <= 1'b1;
                        MRW      <= 1'b0;
                        MADDR    <= IADDR;
                        MWDATA   <= '0;
                    end
                end
                IWAIT, DWAIT: begin
                    if (MACK) begin
                        state <= IDLE;
                        MREQ  <= 1'b0;
                        if (state == IWAIT) begin
                            IVALID <= 1'b1;
                            IDATA  <= MRDATA;
                        end else begin
                            DVALID <= 1'b1;
                            if (!MRW) DRDATA <= MRDATA;
                        end
                    end else if (wait_cnt == TMAX) begin
                        // Abort still retires the request so the pipeline can move on.
                        state <= IDLE;
                        MREQ  <= 1'b0;
                        ERR   <= 1'b1;
                        if (state == IWAIT) begin
                            IVALID <= 1'b1;
                            IDATA  <= '0;
                        end else begin
                            DVALID <= 1'b1;
                            DRDATA <= '0;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a scoreboard queue holds the expected completion per request,
// and a negedge monitor pops and compares it on every IVALID/DVALID pulse.
module tb_mem_port_arbiter;

    localparam int AW = 30;
    localparam int DW = 32;
    localparam int TO = 4;

    logic          CLK = 1'b0;
    logic          RST;
    logic          IREQ;
    logic [AW-1:0] IADDR;
    logic [DW-1:0] IDATA;
    logic          IVALID;
    logic          DREQ;
    logic          DRW;
    logic [AW-1:0] DADDR;
    logic [DW-1:0] DWDATA;
    logic [DW-1:0] DRDATA;
    logic          DVALID;
    logic          STALL;
    logic          ERR;
    logic          MREQ;
    logic          MRW;
    logic [AW-1:0] MADDR;
    logic [DW-1:0] MWDATA;
    logic [DW-1:0] MRDATA;
    logic          MACK;

    mem_port_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
        .CLK(CLK), .RST(RST),
        .IREQ(IREQ), .IADDR(IADDR), .IDATA(IDATA), .IVALID(IVALID),
        .DREQ(DREQ), .DRW(DRW), .DADDR(DADDR), .DWDATA(DWDATA),
        .DRDATA(DRDATA), .DVALID(DVALID),
        .STALL(STALL), .ERR(ERR),
        .MREQ(MREQ), .MRW(MRW), .MADDR(MADDR), .MWDATA(MWDATA),
        .MRDATA(MRDATA), .MACK(MACK)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic          is_d;
        logic [DW-1:0] data;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   errors = 0;
    int   checks = 0;

    logic           prev_mreq, prev_iv, prev_dv;
    logic [AW+DW:0] prev_mbus;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge CLK) begin
        if (RST) begin
            prev_mreq = 1'b0;
            prev_iv   = 1'b0;
            prev_dv   = 1'b0;
        end else begin
            if (IVALID || DVALID) begin
                chk("valid_width", {IVALID & prev_iv, DVALID & prev_dv}, 0);
                if (sb.size() == 0) begin
                    chk("spurious_valid", {IVALID, DVALID}, 0);
                end else begin
                    e = sb.pop_front();
                    chk("valid_side", {IVALID, DVALID}, e.is_d ? 2'b01 : 2'b10);
                    chk("valid_data", e.is_d ? DRDATA : IDATA, e.data);
                end
            end
            if (MREQ && prev_mreq) chk("mbus_stable", {MRW, MADDR, MWDATA}, prev_mbus);
            prev_mreq = MREQ;
            prev_iv   = IVALID;
            prev_dv   = DVALID;
            prev_mbus = {MRW, MADDR, MWDATA};
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_mreq(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge CLK);
            #1;
            if (MREQ) break;
        end
        chk("mreq_seen", MREQ, 1);
    endtask

    task automatic wait_valid(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge CLK);
            #1;
            if (IVALID || DVALID) break;
        end
        chk("valid_seen", IVALID | DVALID, 1);
    endtask

    task automatic pulse_mack(input int delay, input logic [DW-1:0] d);
        repeat (delay) @(posedge CLK);
        #1;
        MACK   = 1'b1;
        MRDATA = d;
        step();
        MACK   = 1'b0;
        MRDATA = '0;
    endtask

    initial begin
        RST = 1'b1; IREQ = 1'b0; IADDR = '0; DREQ = 1'b0; DRW = 1'b0;
        DADDR = '0; DWDATA = '0; MRDATA = '0; MACK = 1'b0;
        repeat (2) @(negedge CLK);
        chk("reset_outputs", {IDATA, IVALID, DRDATA, DVALID, ERR, MREQ, MRW}, 0);
        chk("reset_mbus", {MADDR, MWDATA}, 0);
        step();
        RST = 1'b0;

        // 1: single fetch, MACK three cycles into the wait
        step();
        IREQ = 1'b1; IADDR = 30'h10;
        sb.push_back('{1'b0, 32'hDEADBEEF});
        wait_mreq(4);
        chk("t1_maddr", MADDR, 30'h10);
        chk("t1_mrw", MRW, 0);
        chk("t1_stall_wait", STALL, 1);
        pulse_mack(2, 32'hDEADBEEF);
        wait_valid(4);
        chk("t1_stall_in_valid", STALL, 0);
        step();
        IREQ = 1'b0;
        @(negedge CLK);
        chk("t1_no_regrant", MREQ, 0);

        // 2: simultaneous fetch and load, load wins
        step();
        IREQ = 1'b1; IADDR = 30'h20; DREQ = 1'b1; DRW = 1'b0; DADDR = 30'h40;
        sb.push_back('{1'b1, 32'hCAFE0001});
        sb.push_back('{1'b0, 32'hCAFE0002});
        wait_mreq(4);
        chk("t2_maddr_d_first", MADDR, 30'h40);
        chk("t2_stall", STALL, 1);
        pulse_mack(1, 32'hCAFE0001);
        wait_valid(4);
        chk("t2_stall_d_retire", STALL, 1);
        chk("t2_idle_gap", MREQ, 0);
        step();
        DREQ = 1'b0;
        wait_mreq(4);
        chk("t2_maddr_i_second", MADDR, 30'h20);
        chk("t2_stall_i", STALL, 1);
        pulse_mack(1, 32'hCAFE0002);
        wait_valid(4);
        step();
        IREQ = 1'b0;

        // 3: store keeps DRDATA
        step();
        DREQ = 1'b1; DRW = 1'b1; DADDR = 30'h8; DWDATA = 32'h1234;
        sb.push_back('{1'b1, 32'hCAFE0001});
        wait_mreq(4);
        chk("t3_mrw", MRW, 1);
        chk("t3_mwdata", MWDATA, 32'h1234);
        chk("t3_maddr", MADDR, 30'h8);
        pulse_mack(1, 32'hFFFFFFFF);
        wait_valid(4);
        step();
        DREQ = 1'b0; DRW = 1'b0; DWDATA = '0;

        // 4: load timeout
        step();
        chk("t4_err_before", ERR, 0);
        DREQ = 1'b1; DADDR = 30'h44;
        sb.push_back('{1'b1, 32'h0});
        wait_mreq(4);
        repeat (TO - 1) @(negedge CLK);
        chk("t4_mreq_still_waiting", MREQ, 1);
        wait_valid(TO + 4);
        chk("t4_mreq_dropped", MREQ, 0);
        chk("t4_err_set", ERR, 1);
        step();
        DREQ = 1'b0;

        // 6: back-to-back fetches with stepping address, ERR stays sticky
        step();
        IREQ = 1'b1; IADDR = 30'h0;
        sb.push_back('{1'b0, 32'h11110000});
        wait_mreq(4);
        chk("t6_maddr0", MADDR, 30'h0);
        pulse_mack(0, 32'h11110000);
        wait_valid(4);
        step();
        IADDR = 30'h1;
        sb.push_back('{1'b0, 32'h11110001});
        wait_mreq(4);
        chk("t6_maddr1", MADDR, 30'h1);
        chk("t6_err_sticky", ERR, 1);
        pulse_mack(0, 32'h11110001);
        wait_valid(4);
        step();
        IREQ = 1'b0;
        repeat (2) @(negedge CLK);
        chk("t6_quiet", MREQ, 0);

        // 5: reset mid-DWAIT, then a stray MACK
        step();
        DREQ = 1'b1; DADDR = 30'h50;
        wait_mreq(4);
        RST = 1'b1;
        #1;
        chk("t5_async_clear", {MREQ, ERR, DVALID, IVALID, MRW}, 0);
        chk("t5_async_data", {MADDR, DRDATA, IDATA}, 0);
        DREQ = 1'b0;
        step();
        RST = 1'b0;
        pulse_mack(1, 32'h55AA55AA);
        repeat (3) @(negedge CLK);
        chk("t5_stray_ignored", {MREQ, DVALID, IVALID, ERR}, 0);
        chk("t5_drdata", DRDATA, 0);

        step();
        chk("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
